// File: rtl/dbus_bridge.sv
// Data-bus responder for the CPU MEM stage: decodes each word access between
// external DRAM and a page of memory-mapped peripherals (SEG, LED, SW, CYC).
module dbus_bridge #(
    parameter int SCAN_DIV = 20000,
    parameter int DRAM_AW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               we_i,
    output logic [31:0]        rdata_o,
    output logic [DRAM_AW-1:0] dram_addr_o,
    output logic [31:0]        dram_wdata_o,
    output logic               dram_we_o,
    input  logic [31:0]        dram_rdata_i,
    input  logic [23:0]        sw_i,
    output logic [23:0]        led_o,
    output logic [7:0]         seg_en_o,
    output logic [7:0]         seg_o
);

    // Bus protocol: no handshake. Every cycle is a transaction; reads are
    // answered combinationally, writes commit on the rising edge where we_i=1.
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [9:0] OFF_SEG = 10'h000;
    localparam logic [9:0] OFF_LED = 10'h018;
    localparam logic [9:0] OFF_SW  = 10'h01C;
    localparam logic [9:0] OFF_CYC = 10'h020;

    logic             page_sel;
    logic [9:0]       offset;
    logic             seg_we;
    logic             led_we;
    logic             cyc_we;
    logic [31:0]      seg_q;
    logic [23:0]      led_q;
    logic [23:0]      sw_s1;
    logic [23:0]      sw_s2;
    logic [31:0]      cyc_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [3:0]       digit;
    logic             unused_bits;

    assign unused_bits = ^addr_i[1:0];

    assign page_sel = (addr_i[31:12] == 20'hFFFFF);
    assign offset   = addr_i[11:2];
    assign seg_we   = we_i && page_sel && (offset == OFF_SEG);
    assign led_we   = we_i && page_sel && (offset == OFF_LED);
    assign cyc_we   = we_i && page_sel && (offset == OFF_CYC);

    assign dram_addr_o  = addr_i[DRAM_AW+1:2];
    assign dram_wdata_o = wdata_i;
    assign dram_we_o    = we_i && !page_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            led_q <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            cyc_q <= '0;
            div_q <= '0;
            idx_q <= '0;
        end else begin
            if (seg_we) seg_q <= wdata_i;
            if (led_we) led_q <= wdata_i[23:0];
            sw_s1 <= sw_i;
            sw_s2 <= sw_s1;
            // A clearing write beats the increment in the same cycle.
            cyc_q <= cyc_we ? 32'd0 : cyc_q + 32'd1;
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        if (!page_sel) begin
            rdata_o = dram_rdata_i;
        end else begin
            case (offset)
                OFF_SEG: rdata_o = seg_q;
                OFF_LED: rdata_o = {8'h0, led_q};
                OFF_SW:  rdata_o = {8'h0, sw_s2};
                OFF_CYC: rdata_o = cyc_q;
                default: rdata_o = 32'h0;
            endcase
        end
    end

    assign led_o    = led_q;
    assign digit    = seg_q[{idx_q, 2'b00} +: 4];
    assign seg_en_o = ~(8'b1 << idx_q);

    // Active-low segments, dp held dark.
    always_comb begin
        seg_o = 8'hFF;
        case (digit)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
            default: seg_o = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: directed and random bus cycles, expectations from a
// time-based behavioural model, compared by a negedge monitor.
module tb_dbus_bridge;

    localparam int SCAN_DIV = 4;
    localparam int DRAM_AW  = 16;
    localparam int EW       = 121;

    localparam logic [31:0] A_SEG = 32'hFFFF_F000;
    localparam logic [31:0] A_LED = 32'hFFFF_F060;
    localparam logic [31:0] A_SW  = 32'hFFFF_F070;
    localparam logic [31:0] A_CYC = 32'hFFFF_F080;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        addr_i = '0;
    logic [31:0]        wdata_i = '0;
    logic               we_i = 1'b0;
    logic [31:0]        rdata_o;
    logic [DRAM_AW-1:0] dram_addr_o;
    logic [31:0]        dram_wdata_o;
    logic               dram_we_o;
    logic [31:0]        dram_rdata_i = '0;
    logic [23:0]        sw_i = '0;
    logic [23:0]        led_o;
    logic [7:0]         seg_en_o;
    logic [7:0]         seg_o;

    dbus_bridge #(.SCAN_DIV(SCAN_DIV), .DRAM_AW(DRAM_AW)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
        .rdata_o(rdata_o), .dram_addr_o(dram_addr_o), .dram_wdata_o(dram_wdata_o),
        .dram_we_o(dram_we_o), .dram_rdata_i(dram_rdata_i), .sw_i(sw_i),
        .led_o(led_o), .seg_en_o(seg_en_o), .seg_o(seg_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // n = edges since reset released; everything time-driven derives from it.
    logic [31:0] n;
    logic [31:0] cyc_zero;
    logic [31:0] m_seg;
    logic [23:0] m_led;
    logic [23:0] sw_old;
    logic [23:0] sw_new;
    logic [31:0] sw_change_n;
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic [EW-1:0] exp_q[$];
    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic model_reset();
        n           = 0;
        cyc_zero    = 0;
        m_seg       = 0;
        m_led       = 0;
        sw_old      = 0;
        sw_new      = sw_i;
        sw_change_n = 0;
    endtask

    function automatic logic [23:0] sw_vis();
        return ((n - sw_change_n) >= 32'd2) ? sw_new : sw_old;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a[31:12] != 20'hFFFFF) return dram_rdata_i;
        case ({a[11:2], 2'b00})
            12'h000: return m_seg;
            12'h060: return {8'h0, m_led};
            12'h070: return {8'h0, sw_vis()};
            12'h080: return n - cyc_zero;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_sw(input logic [23:0] v);
        sw_old      = sw_vis();
        sw_new      = v;
        sw_change_n = n;
        sw_i        = v;
    endtask

    // Called just after a rising edge; drives one bus cycle and commits the model.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        logic [2:0] idx;
        logic [3:0] dig;
        logic [7:0] exp_en;
        logic [7:0] exp_seg;
        logic       exp_we;
        rst          = r;
        addr_i       = a;
        wdata_i      = d;
        we_i         = w;
        dram_rdata_i = $urandom;
        idx     = 3'((n / SCAN_DIV) % 8);
        dig     = m_seg[idx*4 +: 4];
        exp_en  = ~(8'd1 << idx);
        exp_seg = seg_tab[dig];
        exp_we  = w && (a[31:12] != 20'hFFFFF);
        exp_q.push_back({model_rdata(a), d, m_led, exp_en, exp_seg, exp_we, a[DRAM_AW+1:2]});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            n = n + 1;
            if (w && a[31:12] == 20'hFFFFF) begin
                case ({a[11:2], 2'b00})
                    12'h000: m_seg = d;
                    12'h060: m_led = d[23:0];
                    12'h080: cyc_zero = n;
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata",      rdata_o,              e[120:89]);
            check("dram_wdata", dram_wdata_o,         e[88:57]);
            check("led",        {8'h0, led_o},        {8'h0, e[56:33]});
            check("seg_en",     {24'h0, seg_en_o},    {24'h0, e[32:25]});
            check("seg",        {24'h0, seg_o},       {24'h0, e[24:17]});
            check("dram_we",    {31'h0, dram_we_o},   {31'h0, e[16]});
            check("dram_addr",  {16'h0, dram_addr_o}, {16'h0, e[15:0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // counter starts at 0 in the first post-reset cycle
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);

        // DRAM path and a peripheral write that must not reach DRAM
        step(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0);
        step(32'h0000_0010, 32'h0, 1'b0, 1'b0);
        step(A_LED, 32'hFFAB_CDEF, 1'b1, 1'b0);
        step(A_LED, 32'h0, 1'b0, 1'b0);

        // switch synchronizer latency
        set_sw(24'h00_5A5A);
        repeat (3) step(A_SW, 32'h0, 1'b0, 1'b0);
        step(32'hFFFF_F0F0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(32'hFFFF_F0F0, 32'h0, 1'b0, 1'b0);
        step(A_SW, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(A_SW, 32'h0, 1'b0, 1'b0);

        // counter clear wins over increment
        step(A_CYC, 32'h55, 1'b1, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);

        // counter wrap via backdoor
        force dut.cyc_q = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_q;
        cyc_zero = n - 32'hFFFF_FFFE;
        repeat (3) step(A_CYC, 32'h0, 1'b0, 1'b0);

        // scan from a clean reset
        step(A_CYC, 32'h0, 1'b0, 1'b1);
        step(A_SEG, 32'h8765_4321, 1'b1, 1'b0);
        step(A_LED, 32'h00C0_FFEE, 1'b1, 1'b0);
        repeat (36) step(A_SEG, 32'h0, 1'b0, 1'b0);

        // mid-scan reset at index 5 discards a concurrent LED write
        while (((n / SCAN_DIV) % 8) != 5) step(A_CYC, 32'h0, 1'b0, 1'b0);
        step(A_LED, 32'h0012_3456, 1'b1, 1'b1);
        step(A_LED, 32'h0, 1'b0, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        step(A_SEG, 32'h0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (i % 5 == 0) set_sw(24'($urandom));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; if (a[31:12] == 20'hFFFFF) a[31] = 1'b0; end
                1: a = A_SEG;
                2: a = A_LED;
                3: a = A_SW;
                4: a = A_CYC;
                default: a = {20'hFFFFF, 12'($urandom)};
            endcase
            step(a, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
